// File: rtl/simproc_pkg.sv
// ------------------------------------------------------------------
// simproc_pkg : shared encodings for the simproc control/datapath/ALU
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package simproc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_IRLD   = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MDRLD  = 4'd4,
    ST_LDWB   = 4'd5,
    ST_STORE  = 4'd6,
    ST_ALU    = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_BRANCH = 4'd9,
    ST_HALT   = 4'd10
  } state_t;

  localparam logic [2:0] OP_ORI_MASK   = 3'b111;
  localparam logic [2:0] OP_SHIFT_MASK = 3'b011;
  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_NAND  = 4'b1000;
  localparam logic [3:0] OP_BZ    = 4'b0101;
  localparam logic [3:0] OP_BNZ   = 4'b1001;
  localparam logic [3:0] OP_BPZ   = 4'b1101;
  localparam logic [3:0] OP_STOP  = 4'b0001;

  localparam logic [2:0] ALUOP_ADD  = 3'b000;
  localparam logic [2:0] ALUOP_SUB  = 3'b001;
  localparam logic [2:0] ALUOP_NAND = 3'b010;
  localparam logic [2:0] ALUOP_OR   = 3'b011;
  localparam logic [2:0] ALUOP_SHL  = 3'b100;
  localparam logic [2:0] ALUOP_SHR  = 3'b101;

  localparam logic [2:0] ALUB_REG   = 3'b000;
  localparam logic [2:0] ALUB_ONE   = 3'b001;
  localparam logic [2:0] ALUB_SEXT4 = 3'b010;
  localparam logic [2:0] ALUB_ZEXT5 = 3'b011;
  localparam logic [2:0] ALUB_ZEXT2 = 3'b100;

  typedef enum logic [1:0] {
    BR_Z  = 2'd0,
    BR_NZ = 2'd1,
    BR_PZ = 2'd2
  } br_t;

  typedef struct packed {
    logic load;
    logic store;
    logic alu;
    logic ori;
    logic shift;
    logic branch;
    logic stop;
    logic nop;
  } iclass_t;

endpackage

`default_nettype wire

// File: rtl/simproc_control_if.sv
// ------------------------------------------------------------------
// simproc_control_if : control-unit <-> datapath strobe bundle
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface simproc_control_if;
  logic [7:0] OpCode;
  logic       N;
  logic       Z;
  logic       PCwrite;
  logic       AddrSel;
  logic       MemRead;
  logic       MemWrite;
  logic       IRload;
  logic       MDRload;
  logic       RASel;
  logic       RFWrite;
  logic       RegIn;
  logic       ABLD;
  logic       ALU_A;
  logic [2:0] ALU_B;
  logic [2:0] ALUop;
  logic       FlagWrite;
  logic       ALUoutLD;
  logic       halted;
  logic [3:0] state;

  modport master (
    input  OpCode, N, Z,
    output PCwrite, AddrSel, MemRead, MemWrite, IRload, MDRload,
           RASel, RFWrite, RegIn, ABLD, ALU_A, ALU_B, ALUop,
           FlagWrite, ALUoutLD, halted, state
  );

  modport slave (
    output OpCode, N, Z,
    input  PCwrite, AddrSel, MemRead, MemWrite, IRload, MDRload,
           RASel, RFWrite, RegIn, ABLD, ALU_A, ALU_B, ALUop,
           FlagWrite, ALUoutLD, halted, state
  );
endinterface

`default_nettype wire

// File: rtl/simproc_decode.sv
// ------------------------------------------------------------------
// simproc_decode : OpCode -> one-hot class, ALU op and branch type
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module simproc_decode
  import simproc_pkg::*;
(
  input  logic [3:0] opcode_i,
  output iclass_t    class_o,
  output logic [2:0] aluop_o,
  output br_t        br_o
);

  always_comb begin
    class_o = '0;
    aluop_o = ALUOP_ADD;
    br_o    = BR_Z;
    // ORI and SHIFT are matched on the low three bits first
    if (opcode_i[2:0] == OP_ORI_MASK) begin
      class_o.ori = 1'b1;
      aluop_o     = ALUOP_OR;
    end else if (opcode_i[2:0] == OP_SHIFT_MASK) begin
      class_o.shift = 1'b1;
      aluop_o       = opcode_i[3] ? ALUOP_SHR : ALUOP_SHL;
    end else begin
      case (opcode_i)
        OP_LOAD:  class_o.load  = 1'b1;
        OP_STORE: class_o.store = 1'b1;
        OP_ADD:   class_o.alu   = 1'b1;
        OP_SUB: begin
          class_o.alu = 1'b1;
          aluop_o     = ALUOP_SUB;
        end
        OP_NAND: begin
          class_o.alu = 1'b1;
          aluop_o     = ALUOP_NAND;
        end
        OP_BZ:    class_o.branch = 1'b1;
        OP_BNZ: begin
          class_o.branch = 1'b1;
          br_o           = BR_NZ;
        end
        OP_BPZ: begin
          class_o.branch = 1'b1;
          br_o           = BR_PZ;
        end
        OP_STOP:  class_o.stop = 1'b1;
        default:  class_o.nop  = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/simproc_control.sv
// ------------------------------------------------------------------
// simproc_control : multicycle fetch/decode/execute/writeback FSM
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module simproc_control
  import simproc_pkg::*;
(
  input  logic               CLOCK_50,
  input  logic               resetn,
  simproc_control_if.master  bus
);

  state_t     state_q;
  state_t     state_d;
  iclass_t    w_class;
  logic [2:0] w_aluop;
  br_t        w_br;
  logic       w_taken;

  simproc_decode u_decode (
    .opcode_i (bus.OpCode[3:0]),
    .class_o  (w_class),
    .aluop_o  (w_aluop),
    .br_o     (w_br)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) state_q <= ST_FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = ST_IRLD;
      ST_IRLD:   state_d = ST_DECODE;
      ST_DECODE: begin
        if (w_class.load)                                state_d = ST_MEMRD;
        else if (w_class.store)                          state_d = ST_STORE;
        else if (w_class.alu || w_class.ori || w_class.shift) state_d = ST_ALU;
        else if (w_class.branch)                         state_d = ST_BRANCH;
        else if (w_class.stop)                           state_d = ST_HALT;
        else if (w_class.nop)                            state_d = ST_FETCH;
      end
      ST_MEMRD:  state_d = ST_MDRLD;
      ST_MDRLD:  state_d = ST_LDWB;
      ST_ALU:    state_d = ST_ALUWB;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    case (w_br)
      BR_Z:    w_taken = bus.Z;
      BR_NZ:   w_taken = !bus.Z;
      BR_PZ:   w_taken = !bus.N;
      default: w_taken = 1'b0;
    endcase
  end

  // Everything is gated by resetn so an aborted instruction commits nothing
  always_comb begin
    bus.PCwrite   = 1'b0;
    bus.AddrSel   = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRload    = 1'b0;
    bus.MDRload   = 1'b0;
    bus.RASel     = 1'b0;
    bus.RFWrite   = 1'b0;
    bus.RegIn     = 1'b0;
    bus.ABLD      = 1'b0;
    bus.ALU_A     = 1'b0;
    bus.ALU_B     = ALUB_REG;
    bus.ALUop     = ALUOP_ADD;
    bus.FlagWrite = 1'b0;
    bus.ALUoutLD  = 1'b0;
    bus.halted    = 1'b0;
    bus.state     = 4'd0;
    if (resetn) begin
      bus.state = state_q;
      case (state_q)
        ST_FETCH: begin
          bus.AddrSel = 1'b1;
          bus.MemRead = 1'b1;
        end
        ST_IRLD: begin
          bus.AddrSel = 1'b1;
          bus.MemRead = 1'b1;
          bus.IRload  = 1'b1;
          bus.ALU_B   = ALUB_ONE;
          bus.PCwrite = 1'b1;
        end
        ST_DECODE: begin
          bus.ABLD  = 1'b1;
          bus.RASel = w_class.ori;
        end
        ST_MEMRD:  bus.MemRead = 1'b1;
        ST_MDRLD:  bus.MDRload = 1'b1;
        ST_LDWB: begin
          bus.RegIn   = 1'b1;
          bus.RFWrite = 1'b1;
        end
        ST_STORE:  bus.MemWrite = 1'b1;
        ST_ALU: begin
          bus.ALU_A     = 1'b1;
          bus.ALUoutLD  = 1'b1;
          bus.FlagWrite = 1'b1;
          bus.RASel     = w_class.ori;
          bus.ALU_B     = w_class.ori ? ALUB_ZEXT5 : ALUB_REG;
          bus.ALUop     = w_aluop;
        end
        ST_ALUWB: begin
          bus.RFWrite = 1'b1;
          bus.RASel   = w_class.ori;
        end
        ST_BRANCH: begin
          bus.ALU_B   = ALUB_SEXT4;
          bus.PCwrite = w_taken;
        end
        ST_HALT:   bus.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/simproc_control.md
# simproc_control

Multicycle control unit for the 8-bit simple processor. Sequences fetch, decode, execute and writeback for every instruction by driving all datapath control strobes from a Moore/Mealy state machine. Consumes the instruction register (`OpCode`) and registered flags (`N`, `Z`) produced by the datapath, and sits directly upstream of it on every control input.

## Interface
- No parameters. Encodings are fixed in `simproc_pkg`.
- `CLOCK_50` in 1 — system clock; all state changes on rising edge.
- `resetn` in 1 — synchronous, active-low reset.
- `OpCode` in 8 — instruction register contents. R1=`[7:6]`, R2=`[5:4]`, opcode in low bits.
- `N`, `Z` in 1 each — registered flags from the last flag-setting instruction.
- `PCwrite`, `AddrSel`, `MemRead`, `MemWrite`, `IRload`, `MDRload` out 1 each — PC, address and memory strobes. `AddrSel`: 1=PC, 0=B register.
- `RASel`, `RFWrite`, `RegIn`, `ABLD` out 1 each — register file control. `RASel`=1 forces register 1. `RegIn`: 1=MDR, 0=ALU register.
- `ALU_A` out 1 — 0=PC, 1=A register.
- `ALU_B` out 3 — 000 B register; 001 const 1; 010 sext `IR[7:4]`; 011 zext `IR[7:3]`; 100 zext `IR[7:6]`.
- `ALUop` out 3 — 000 ADD, 001 SUB, 010 NAND, 011 OR, 100 SHL, 101 SHR.
- `FlagWrite`, `ALUoutLD` out 1 each — flag and ALU-result register loads.
- `halted` out 1 — high while in HALT.
- `state` out 4 — current state, for debug and LEDs.

## Operation
- Opcode classes, checked in this priority order:
  - `IR[2:0]`=111: ORI, k1 ← k1 | imm5.
  - `IR[2:0]`=011: SHIFT, R1 ← R1 shifted by R2. `IR[3]`=0 selects left, 1 selects right.
  - `IR[3:0]`=0000 LOAD: R1 ← mem[R2].
  - 0010 STORE: mem[R2] ← R1.
  - 0100 ADD, 0110 SUB, 1000 NAND: R1 ← R1 op R2.
  - 0101 BZ, 1001 BNZ, 1101 BPZ: branch.
  - 0001 STOP.
  - Any other code is a NOP.
- States and what each asserts:
  - FETCH(0): `AddrSel`=1, `MemRead`=1.
  - IRLD(1): `AddrSel`=1, `MemRead`=1, `IRload`=1, `ALU_A`=0, `ALU_B`=001, ADD, `PCwrite`=1.
  - DECODE(2): `ABLD`=1; `RASel`=1 if ORI.
  - MEMRD(3): `AddrSel`=0, `MemRead`=1.
  - MDRLD(4): `MDRload`=1.
  - LDWB(5): `RegIn`=1, `RFWrite`=1.
  - STORE(6): `AddrSel`=0, `MemWrite`=1.
  - ALU(7): `ALU_A`=1, `ALUoutLD`=1, `FlagWrite`=1. `ALU_B`/`ALUop` per class: ORI 011/OR; others 000 with their op.
  - ALUWB(8): `RegIn`=0, `RFWrite`=1.
  - BRANCH(9): `ALU_A`=0, `ALU_B`=010, ADD; `PCwrite`=1 only if taken.
  - HALT(10): no strobes.
- Transitions:
  - FETCH→IRLD→DECODE.
  - From DECODE: LOAD→MEMRD→MDRLD→LDWB→FETCH.
  - STORE→STORE state→FETCH.
  - ALU classes (ORI, SHIFT, ADD, SUB, NAND)→ALU→ALUWB→FETCH.
  - Branches→BRANCH→FETCH.
  - STOP→HALT, held until reset.
  - NOP→FETCH.
- Branch taken conditions: BZ when Z=1, BNZ when Z=0, BPZ when N=0. Target is PC+1+sext(imm4), since PC was already incremented in IRLD.
- `RASel`=1 is held through DECODE, ALU and ALUWB for ORI. It is 0 everywhere else.
- Unused states 11–15 go to FETCH on the next edge with all strobes 0.

## Timing
- Strobes are combinational decodes of registered state and `OpCode`/`N`/`Z`. No strobe depends on another strobe.
- `OpCode` is sampled only from DECODE onward; it is valid because `IRload` fired in IRLD.
- CPI: LOAD 6, ALU classes 5, STORE 4, branch 4 (taken or not), NOP 3.
- Flags sampled in BRANCH reflect the last ALU state. LOAD and STORE never assert `FlagWrite`.
- Reset:
  - While `resetn`=0 on an edge, state goes to FETCH.
  - In any cycle with `resetn`=0, all outputs are forced to 0, `halted`=0 and `state` reads 0.
  - Reset mid-instruction aborts it: no `PCwrite`, `RFWrite` or `MemWrite` in that cycle. A partially executed LOAD writes nothing.
  - PC reset is outside this block.
- At most one of `MemRead`/`MemWrite` per cycle. `RFWrite` and `PCwrite` are never high together.

## Structure
- `simproc_pkg`: state enum (4-bit), opcode constants and masks, `ALUop` codes, `ALU_B` select codes. Shared with the datapath and ALU.
- Sub-module `simproc_decode`: combinational `OpCode` → one-hot class (load, store, alu, ori, shift, branch, stop, nop), ALU op, and branch type.
- `simproc_control` holds the state register and output decode.

## Test plan
- Reset then LOAD `OpCode`=0x10 (R0←mem[R1]) → states 0,1,2,3,4,5,0. `MDRload` in cycle 4, `RFWrite`+`RegIn` in cycle 5; no `FlagWrite`.
- ADD 0x14 then SUB 0x26 → 5 cycles each. `ALUop` 000 then 001 in ALU state; `FlagWrite`+`ALUoutLD` once each.
- ORI 0xFF (imm5=31) → `RASel`=1 in DECODE, ALU and ALUWB; `ALU_B`=011, `ALUop`=011.
- BZ 0xF5 with Z=1 → `PCwrite`=1 in BRANCH, `ALU_B`=010. With Z=0 → `PCwrite`=0. BPZ 0x0D with N=1 → not taken.
- STOP 0x01 → HALT reached after DECODE, `halted`=1 and held for 20 cycles. `resetn`=0 for one edge → FETCH, `halted`=0.
- `resetn` low during MDRLD of a LOAD → no `RFWrite` ever asserted for it; next cycle state=FETCH and all outputs 0 during reset.
